// File: rtl/axi4_lite_slave_write_responder_if.sv
// rtl/axi4_lite_slave_write_responder_if.sv - AXI4-Lite write channels (AW, W, B) bundle
interface axi4_lite_slave_write_responder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi4_lite_slave_write_responder.sv
// rtl/axi4_lite_slave_write_responder.sv - AXI4-Lite write slave with delayed ready and register bank
// Optional byte-strobe merging is enabled with `define AXI4LITE_WSTRB_EN.
module axi4_lite_slave_write_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DELAY_WIDTH   = 4,
    parameter int NUM_REGS      = 16,
    localparam int IDX_WIDTH    = $clog2(NUM_REGS)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi4_lite_slave_write_responder_if.slave s_axi,
    input  logic [DELAY_WIDTH-1:0] cfgReadyDelay,
    input  logic [IDX_WIDTH-1:0]   regRdIdx,
    output logic [DATA_WIDTH-1:0]  regRdData
);
    typedef enum logic [1:0] {IDLE, DELAY, ACCEPT, RESP} state_t;

    state_t                    state, next_state;
    logic [DELAY_WIDTH-1:0]    delay_cnt;
    logic                      aw_got, w_got;
    logic                      aw_hs, w_hs, commit;
    logic [ADDRESS_WIDTH-1:0]  aw_addr_q;
    logic [2:0]                aw_prot_q;
    logic [DATA_WIDTH-1:0]     w_data_q;
    logic [DATA_WIDTH/8-1:0]   w_strb_q;
    logic [1:0]                bresp_q;
    logic [DATA_WIDTH-1:0]     bank [NUM_REGS];

    logic [ADDRESS_WIDTH-1:0]  commit_addr;
    logic [DATA_WIDTH-1:0]     commit_data;
    logic [DATA_WIDTH/8-1:0]   commit_strb;
    logic [ADDRESS_WIDTH-3:0]  word_idx;
    logic [IDX_WIDTH-1:0]      wr_idx;
    logic                      addr_err;
    logic [DATA_WIDTH-1:0]     new_word;

    // A channel that handshakes in the commit cycle has not been latched yet, so use the live bus value.
    assign commit_addr = aw_got ? aw_addr_q : s_axi.awaddr;
    assign commit_data = w_got  ? w_data_q  : s_axi.wdata;
    assign commit_strb = w_got  ? w_strb_q  : s_axi.wstrb;
    assign word_idx    = commit_addr[ADDRESS_WIDTH-1:2];
    assign wr_idx      = word_idx[IDX_WIDTH-1:0];
    assign addr_err    = (commit_addr[1:0] != 2'b00) ||
                         (word_idx >= (ADDRESS_WIDTH-2)'(NUM_REGS));

`ifdef AXI4LITE_WSTRB_EN
    always_comb begin
        new_word = bank[wr_idx];
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (commit_strb[i]) new_word[8*i +: 8] = commit_data[8*i +: 8];
        end
    end
`else
    assign new_word = commit_data;
    wire unused_strb = ^commit_strb;
`endif

    wire unused_prot = ^aw_prot_q;

    always_comb begin
        next_state    = state;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        commit        = 1'b0;
        case (state)
            IDLE: begin
                if (s_axi.awvalid || s_axi.wvalid)
                    next_state = (cfgReadyDelay == '0) ? ACCEPT : DELAY;
            end
            DELAY: begin
                if (delay_cnt <= DELAY_WIDTH'(1)) next_state = ACCEPT;
            end
            ACCEPT: begin
                s_axi.awready = !aw_got;
                s_axi.wready  = !w_got;
                aw_hs         = s_axi.awvalid && !aw_got;
                w_hs          = s_axi.wvalid && !w_got;
                if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                    commit     = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            delay_cnt <= '0;
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_addr_q <= '0;
            aw_prot_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= 2'b00;
            for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
        end else begin
            if (state == IDLE && (s_axi.awvalid || s_axi.wvalid))
                delay_cnt <= cfgReadyDelay;
            else if (state == DELAY)
                delay_cnt <= delay_cnt - DELAY_WIDTH'(1);
            if (aw_hs) begin
                aw_got    <= 1'b1;
                aw_addr_q <= s_axi.awaddr;
                aw_prot_q <= s_axi.awprot;
            end
            if (w_hs) begin
                w_got    <= 1'b1;
                w_data_q <= s_axi.wdata;
                w_strb_q <= s_axi.wstrb;
            end
            if (commit) begin
                bresp_q <= addr_err ? 2'b10 : 2'b00;
                if (!addr_err) bank[wr_idx] <= new_word;
            end
            if (state == RESP && s_axi.bready) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
        end
    end

    assign s_axi.bresp = bresp_q;
    assign regRdData   = bank[regRdIdx];
endmodule

// File: tb/tb_axi4_lite_slave_write_responder.sv
// tb/tb_axi4_lite_slave_write_responder.sv - randomized bench with timing and register-bank reference model
module tb_axi4_lite_slave_write_responder;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DLW = 4;
    localparam int NR = 16;
    localparam int IW = 4;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [DLW-1:0] cfgReadyDelay = '0;
    logic [IW-1:0]  regRdIdx = '0;
    logic [DW-1:0]  regRdData;

    axi4_lite_slave_write_responder_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_lite_slave_write_responder #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DELAY_WIDTH(DLW), .NUM_REGS(NR)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi         (bus.slave),
        .cfgReadyDelay (cfgReadyDelay),
        .regRdIdx      (regRdIdx),
        .regRdData     (regRdData)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NR];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic run_txn(input int dly, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_st, input int w_st,
                           input int hold, input bit rst_in_resp);
        int ready_c = -1;
        int b_c = -1;
        int exp_ready, exp_b, aw_hs_c, w_hs_c;
        bit aw_done = 0;
        bit w_done = 0;
        bit err;
        logic [1:0]  exp_resp;
        logic [31:0] exp_word;
        logic [3:0]  idx;

        idx = addr[5:2];
        err = (addr[1:0] != 2'b00) || ((addr >> 2) >= NR);
        exp_resp = err ? 2'b10 : 2'b00;
        exp_word = model[idx];
        if (!err) begin
`ifdef AXI4LITE_WSTRB_EN
            for (int b = 0; b < 4; b++) if (strb[b]) exp_word[8*b +: 8] = data[8*b +: 8];
`else
            exp_word = data;
`endif
        end
        exp_ready = ((aw_st < w_st) ? aw_st : w_st) + dly + 1;
        aw_hs_c   = (aw_st > exp_ready) ? aw_st : exp_ready;
        w_hs_c    = (w_st > exp_ready) ? w_st : exp_ready;
        exp_b     = ((aw_hs_c > w_hs_c) ? aw_hs_c : w_hs_c) + 1;

        cfgReadyDelay = DLW'(dly);
        regRdIdx      = idx;
        bus.awaddr    = addr;
        bus.awprot    = 3'($urandom);
        bus.wdata     = data;
        bus.wstrb     = strb;
        bus.bready    = 1'b0;

        for (int c = 0; c < 64 && b_c < 0; c++) begin
            bus.awvalid = (c >= aw_st) && !aw_done;
            bus.wvalid  = (c >= w_st) && !w_done;
            if (ready_c < 0 && (bus.awready || bus.wready)) ready_c = c;
            if (bus.bvalid) begin
                b_c = c;
            end else begin
                if (bus.awvalid && bus.awready) aw_done = 1;
                if (bus.wvalid && bus.wready) w_done = 1;
                tick();
            end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;

        check("ready_cycle", 64'(ready_c), 64'(exp_ready));
        check("bvalid_cycle", 64'(b_c), 64'(exp_b));
        if (b_c < 0) return;
        check("bresp", bus.bresp, exp_resp);
        check("bank_at_bvalid", regRdData, exp_word);
        model[idx] = exp_word;

        if (rst_in_resp) begin
            aresetn = 1'b0;
            tick();
            aresetn = 1'b1;
            for (int i = 0; i < NR; i++) model[i] = '0;
            check("rst_bvalid", bus.bvalid, 1'b0);
            check("rst_bresp", bus.bresp, 2'b00);
            check("rst_readies", {bus.awready, bus.wready}, 2'b00);
            check("rst_bank", regRdData, model[idx]);
            return;
        end

        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_bvalid", bus.bvalid, 1'b1);
            check("hold_bresp", bus.bresp, exp_resp);
            check("hold_awready", bus.awready, 1'b0);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("b_done", bus.bvalid, 1'b0);
    endtask

    initial begin
        logic [31:0] addr;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0;  bus.wstrb = '0;  bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        for (int i = 0; i < NR; i++) model[i] = '0;

        tick();
        tick();
        check("reset_awready", bus.awready, 1'b0);
        check("reset_wready", bus.wready, 1'b0);
        check("reset_bvalid", bus.bvalid, 1'b0);
        check("reset_bresp", bus.bresp, 2'b00);
        regRdIdx = 4'd5;
        #1;
        check("reset_bank", regRdData, 32'h0);
        aresetn = 1'b1;
        tick();

        run_txn(0, 32'h8,  32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        run_txn(3, 32'h0,  32'h01234567, 4'hF, 0, 6, 1, 0);
        run_txn(1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
        run_txn(2, 32'h6,  32'hCAFEF00D, 4'hF, 1, 0, 0, 0);
        run_txn(0, 32'h4,  32'h55AA55AA, 4'hF, 2, 0, 5, 0);
        run_txn(0, 32'h0,  32'h11223344, 4'hF, 0, 0, 0, 0);
        run_txn(0, 32'h0,  32'hAABBCCDD, 4'h5, 0, 0, 0, 0);
        regRdIdx = 4'd0;
        #1;
`ifdef AXI4LITE_WSTRB_EN
        check("strobe_merge", regRdData, 32'h11BB33DD);
`else
        check("strobe_ignored", regRdData, 32'hAABBCCDD);
`endif

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 9))
                7:       addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                8:       addr = 32'h40 + (32'($urandom_range(0, 15)) << 2);
                9:       addr = ($urandom | 32'h1000_0000) & ~32'h3;
                default: addr = 32'($urandom_range(0, 15)) << 2;
            endcase
            run_txn($urandom_range(0, 5), addr, $urandom, 4'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 0);
        end

        run_txn(2, 32'hC, 32'h0BADC0DE, 4'hF, 0, 1, 0, 1);
        regRdIdx = 4'd3;
        #1;
        check("reset_reg3", regRdData, 32'h0);
        run_txn(0, 32'h10, 32'h76543210, 4'hF, 0, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_lite_slave_write_responder.md
Name: axi4_lite_slave_write_responder

Overview:
- Slave-side AXI4-Lite write responder; the target end of the write channels driven by the master agent.
- Accepts AW and W independently, inserts a programmable ready delay and writes an internal word-addressed register bank.
- Returns BRESP (OKAY/SLVERR) on the B channel.
- Sits behind the slave agent interface as the synthesizable DUT-side endpoint; a side read port exposes the bank to the scoreboard.

Parameters:
- ADDRESS_WIDTH, 32, AW address width
- DATA_WIDTH, 32, W data width; fixed at 32 (one word per register)
- DELAY_WIDTH, 4, width of ready-delay configuration
- NUM_REGS, 16, number of 32-bit registers in the bank; power of two, 2..256

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  synchronous, active-low reset
- awaddr  in  ADDRESS_WIDTH  write address
- awprot  in  3  protection; captured, not acted on
- awvalid  in  1  address valid
- awready  out  1  address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- wvalid  in  1  data valid
- wready  out  1  data ready
- bresp  out  2  00 = WRITE_OKAY, 10 = WRITE_SLVERR
- bvalid  out  1  response valid
- bready  in  1  response ready
- cfgReadyDelay  in  DELAY_WIDTH  cycles to hold ready low after first valid
- regRdIdx  in  $clog2(NUM_REGS)  side read index
- regRdData  out  DATA_WIDTH  combinational bank[regRdIdx]

Behaviour:
- Reset (aresetn=0 at edge): state IDLE; awready=wready=bvalid=0; bresp=00; capture flags clear; delay counter 0; all registers 0. Reset mid-transaction abandons it; no write, no response.
- FSM states: IDLE, DELAY, ACCEPT, RESP.
- IDLE: readies low.
  - On awvalid|wvalid: load counter with cfgReadyDelay, sampled only here.
  - Go to DELAY, or to ACCEPT if cfgReadyDelay==0.
- DELAY: counter decrements each cycle; when it reaches 1, go to ACCEPT. Readies are first high exactly cfgReadyDelay+1 cycles after first valid seen in IDLE.
- ACCEPT:
  - awready = !awGot; wready = !wGot.
  - AW handshake latches awaddr/awprot and sets awGot; W handshake latches wdata/wstrb and sets wGot.
  - Both may complete in the same cycle, in either order, or on separate cycles.
  - On the edge where both flags become or are set: commit the write, drive bvalid=1 with bresp, go to RESP.
- Decode, evaluated at commit:
  - idx = addr[ADDRESS_WIDTH-1:2].
  - SLVERR and no register change if addr[1:0]!=0 or idx>=NUM_REGS. Otherwise OKAY.
- RESP: readies low; bvalid and bresp held stable until bready. On bvalid&bready: bvalid=0, flags clear, go to IDLE. Earliest next acceptance is one cycle later.
- Latency with delay 0, valids at cycle 0: ready high cycle 1, bvalid high cycle 2.
- Register write is visible on regRdData the cycle bvalid rises.
- Valid dropped before handshake is a master protocol violation; behaviour unspecified, and the FSM does not hang.

Optional Feature:
- AXI4LITE_WSTRB_EN defined: only bytes with wstrb[i]=1 are updated. wstrb==0 on a valid address gives OKAY with no change.
- Undefined: wstrb ignored; full 32-bit word written.

Test Plan:
- cfgReadyDelay=0; AW 0x0000_0008 and W 0xDEADBEEF (wstrb=F) in cycle 0 -> awready/wready high cycle 1, bvalid cycle 2, bresp=00, regRdIdx=2 reads 0xDEADBEEF.
- cfgReadyDelay=3; AW at cycle 0, W at cycle 6 -> awready first high cycle 4; wready held until W handshake cycle 6; bvalid cycle 7, OKAY.
- Address 0x0000_0040 (idx 16, NUM_REGS=16) and address 0x0000_0006 -> each returns bresp=10; bank unchanged.
- bready held low 5 cycles after bvalid -> bvalid/bresp stable throughout; awready stays 0 during RESP; next AW accepted only after the B handshake.
- With AXI4LITE_WSTRB_EN: reg0=0x11223344, write 0xAABBCCDD wstrb=0101 -> reg0=0x11BB33DD. Without the macro -> 0xAABBCCDD.
- aresetn low for one edge while in RESP with reg3 written -> bvalid=0, FSM IDLE, reg3 reads 0.
